// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_IF   = 2'd1,
    WAIT_LS   = 2'd2,
    WAIT_DROP = 2'd3
  } arb_state_t;

  localparam int BE_W = 4;
  localparam logic [BE_W-1:0] BE_ALL = 4'hF;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, LSU, flush and memory-side signals around the arbiter.
interface mem_port_arbiter_if #(parameter int size = 32);
  import mem_arb_pkg::*;

  logic            if_req_i;
  logic [size-1:0] if_addr_i;
  logic            if_gnt_o;
  logic            if_rvalid_o;
  logic [size-1:0] if_rdata_o;

  logic            ls_req_i;
  logic            ls_we_i;
  logic [BE_W-1:0] ls_be_i;
  logic [size-1:0] ls_addr_i;
  logic [size-1:0] ls_wdata_i;
  logic            ls_gnt_o;
  logic            ls_rvalid_o;
  logic [size-1:0] ls_rdata_o;

  logic            mem_req_o;
  logic            mem_we_o;
  logic [BE_W-1:0] mem_be_o;
  logic [size-1:0] mem_addr_o;
  logic [size-1:0] mem_wdata_o;
  logic            mem_gnt_i;
  logic            mem_rvalid_i;
  logic [size-1:0] mem_rdata_i;

  logic            flush_i;

  // Arbiter side.
  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  ls_req_i, ls_we_i, ls_be_i, ls_addr_i, ls_wdata_i,
    output ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  flush_i
  );

  // Requesters and memory side.
  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output ls_req_i, ls_we_i, ls_be_i, ls_addr_i, ls_wdata_i,
    input  ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output flush_i
  );
endinterface

// File: rtl/mem_port_arbiter_starve_counter.sv
// Counts LSU grants taken while fetch waits; saturates at LIMIT, sat flags it.
module starve_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);
  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  assign sat = (cnt == W'(LIMIT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and LSU, one transaction in flight;
// LSU has priority until fetch has been passed over STARVE_LIMIT times.
module mem_port_arbiter #(
  parameter int size         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              reset,
  mem_port_arbiter_if.slave bus
);
  import mem_arb_pkg::*;

  arb_state_t state_q, state_d;
  logic       sat, inc, clr;
  logic       fetch_sel, ls_sel;

  starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk   (clk),
    .reset (reset),
    .inc   (inc),
    .clr   (clr),
    .sat   (sat)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    inc             = 1'b0;
    clr             = 1'b0;
    fetch_sel       = 1'b0;
    ls_sel          = 1'b0;
    bus.if_gnt_o    = 1'b0;
    bus.if_rvalid_o = 1'b0;
    bus.if_rdata_o  = {size{1'b0}};
    bus.ls_gnt_o    = 1'b0;
    bus.ls_rvalid_o = 1'b0;
    bus.ls_rdata_o  = {size{1'b0}};
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_be_o    = '0;
    bus.mem_addr_o  = {size{1'b0}};
    bus.mem_wdata_o = {size{1'b0}};

    // Reset gates every output so nothing leaks while the block is held.
    if (reset) begin
      case (state_q)
        IDLE: begin
          fetch_sel = bus.if_req_i && !bus.flush_i && (!bus.ls_req_i || sat);
          ls_sel    = bus.ls_req_i && !fetch_sel;
          if (fetch_sel) begin
            bus.mem_req_o  = 1'b1;
            bus.mem_be_o   = BE_ALL;
            bus.mem_addr_o = bus.if_addr_i;
          end else if (ls_sel) begin
            bus.mem_req_o   = 1'b1;
            bus.mem_we_o    = bus.ls_we_i;
            bus.mem_be_o    = bus.ls_be_i;
            bus.mem_addr_o  = bus.ls_addr_i;
            bus.mem_wdata_o = bus.ls_wdata_i;
          end
          if (bus.mem_gnt_i && fetch_sel) begin
            bus.if_gnt_o = 1'b1;
            clr          = 1'b1;
            state_d      = WAIT_IF;
          end else if (bus.mem_gnt_i && ls_sel) begin
            bus.ls_gnt_o = 1'b1;
            inc          = bus.if_req_i;
            state_d      = WAIT_LS;
          end
        end
        WAIT_IF: begin
          if (bus.mem_rvalid_i) begin
            if (!bus.flush_i) begin
              bus.if_rvalid_o = 1'b1;
              bus.if_rdata_o  = bus.mem_rdata_i;
            end
            state_d = IDLE;
          end else if (bus.flush_i) begin
            state_d = WAIT_DROP;
          end
        end
        WAIT_LS: begin
          if (bus.mem_rvalid_i) begin
            bus.ls_rvalid_o = 1'b1;
            bus.ls_rdata_o  = bus.mem_rdata_i;
            state_d         = IDLE;
          end
        end
        WAIT_DROP: begin
          if (bus.mem_rvalid_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: stimulus pushes expected grant/response events, a negedge monitor pops and compares.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.size(32)) bus();

  mem_port_arbiter #(.size(32), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam int K_IG = 0;  // fetch grant
  localparam int K_LG = 1;  // LSU grant
  localparam int K_IR = 2;  // fetch response
  localparam int K_LR = 3;  // LSU response

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  c;
  } ev_t;

  ev_t exp_q[$];
  int  n_vec = 0;
  int  n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] c);
    ev_t e;
    e.kind = kind; e.a = a; e.b = b; e.c = c;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] c);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL unexpected_event: got kind %0d data %h, required no event (t=%0t)",
               kind, a, $time);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", 64'(kind), 64'(e.kind));
      chk("event_addr_or_rdata", 64'(a), 64'(e.a));
      chk("event_wdata", 64'(b), 64'(e.b));
      chk("event_we_be", 64'(c), 64'(e.c));
    end
  endtask

  always @(negedge clk) begin
    if (bus.if_gnt_o) begin
      chk("gnt_with_req", 64'(bus.mem_req_o), 64'd1);
      observe(K_IG, bus.mem_addr_o, bus.mem_wdata_o, {bus.mem_we_o, bus.mem_be_o});
    end
    if (bus.ls_gnt_o) begin
      chk("gnt_with_req", 64'(bus.mem_req_o), 64'd1);
      observe(K_LG, bus.mem_addr_o, bus.mem_wdata_o, {bus.mem_we_o, bus.mem_be_o});
    end
    if (bus.if_rvalid_o) observe(K_IR, bus.if_rdata_o, 32'd0, 5'd0);
    if (bus.ls_rvalid_o) observe(K_LR, bus.ls_rdata_o, 32'd0, 5'd0);
    if (bus.mem_rvalid_i && !bus.if_rvalid_o) chk("if_rdata_zero", 64'(bus.if_rdata_o), 64'd0);
    if (bus.mem_rvalid_i && !bus.ls_rvalid_o) chk("ls_rdata_zero", 64'(bus.ls_rdata_o), 64'd0);
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time %0t exceeded, required completion", $time);
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.if_req_i     = 1'b0;
    bus.if_addr_i    = '0;
    bus.ls_req_i     = 1'b0;
    bus.ls_we_i      = 1'b0;
    bus.ls_be_i      = '0;
    bus.ls_addr_i    = '0;
    bus.ls_wdata_i   = '0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    bus.flush_i      = 1'b0;
  endtask

  function automatic logic any_out();
    return |{bus.if_gnt_o, bus.if_rvalid_o, bus.if_rdata_o, bus.ls_gnt_o, bus.ls_rvalid_o,
             bus.ls_rdata_o, bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o,
             bus.mem_wdata_o};
  endfunction

  // Fetch granted immediately, response lat cycles after the grant cycle.
  task automatic fetch_txn(input logic [31:0] addr, input int lat, input logic [31:0] data);
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = addr;
    bus.mem_gnt_i = 1'b1;
    expect_ev(K_IG, addr, 32'd0, 5'h0F);
    cyc();
    bus.if_req_i  = 1'b0;
    bus.mem_gnt_i = 1'b0;
    repeat (lat - 1) cyc();
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = data;
    expect_ev(K_IR, data, 32'd0, 5'd0);
    cyc();
    clear_in();
  endtask

  initial begin
    clear_in();
    // Reset held with every requester and memory input active.
    bus.if_req_i     = 1'b1;
    bus.ls_req_i     = 1'b1;
    bus.mem_gnt_i    = 1'b1;
    bus.mem_rvalid_i = 1'b1;
    #12;
    chk("outputs_zero_in_reset", 64'(any_out()), 64'd0);
    clear_in();
    cyc();
    reset = 1'b1;
    cyc();

    // Fetch only: grant at cycle 0, response at cycle 2.
    fetch_txn(32'h100, 2, 32'h0000_0013);

    // Contention: LSU x4, fetch, LSU x4, fetch.
    bus.if_req_i     = 1'b1;
    bus.if_addr_i    = 32'h300;
    bus.ls_req_i     = 1'b1;
    bus.ls_we_i      = 1'b0;
    bus.ls_be_i      = 4'hF;
    bus.ls_addr_i    = 32'h400;
    bus.ls_wdata_i   = 32'h55;
    bus.mem_gnt_i    = 1'b1;
    bus.mem_rvalid_i = 1'b1;
    for (int t = 0; t < 10; t++) begin
      bus.mem_rdata_i = 32'h1000 + 32'(t);
      if (t % 5 == 4) expect_ev(K_IG, 32'h300, 32'd0, 5'h0F);
      else            expect_ev(K_LG, 32'h400, 32'h55, 5'h0F);
      cyc();
      if (t % 5 == 4) expect_ev(K_IR, 32'h1000 + 32'(t), 32'd0, 5'd0);
      else            expect_ev(K_LR, 32'h1000 + 32'(t), 32'd0, 5'd0);
      cyc();
    end
    clear_in();
    cyc();

    // Flush after grant: response dropped, waiting LSU granted afterwards.
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h200;
    bus.mem_gnt_i = 1'b1;
    expect_ev(K_IG, 32'h200, 32'd0, 5'h0F);
    cyc();
    bus.if_req_i  = 1'b0;
    bus.flush_i   = 1'b1;
    bus.ls_req_i  = 1'b1;
    bus.ls_be_i   = 4'hF;
    bus.ls_addr_i = 32'h500;
    cyc();
    bus.flush_i = 1'b0;
    #1;
    chk("no_req_in_wait", 64'(bus.mem_req_o), 64'd0);
    cyc();
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'hBAD;
    cyc();
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    expect_ev(K_LG, 32'h500, 32'd0, 5'h0F);
    cyc();
    bus.ls_req_i     = 1'b0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h77;
    expect_ev(K_LR, 32'h77, 32'd0, 5'd0);
    cyc();
    clear_in();

    // Flush coinciding with the response suppresses it and returns to IDLE.
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h240;
    bus.mem_gnt_i = 1'b1;
    expect_ev(K_IG, 32'h240, 32'd0, 5'h0F);
    cyc();
    bus.if_addr_i    = 32'h280;
    bus.flush_i      = 1'b1;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h99;
    cyc();
    bus.flush_i      = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    expect_ev(K_IG, 32'h280, 32'd0, 5'h0F);
    cyc();
    bus.if_req_i     = 1'b0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h44;
    expect_ev(K_IR, 32'h44, 32'd0, 5'd0);
    cyc();
    clear_in();

    // Flush in IDLE blocks fetch but not LSU; flush in WAIT_LS is ignored.
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h2C0;
    bus.flush_i   = 1'b1;
    bus.mem_gnt_i = 1'b1;
    #1;
    chk("flush_blocks_fetch_req", 64'(bus.mem_req_o), 64'd0);
    bus.ls_req_i   = 1'b1;
    bus.ls_be_i    = 4'hF;
    bus.ls_addr_i  = 32'h540;
    bus.ls_wdata_i = 32'h11;
    expect_ev(K_LG, 32'h540, 32'h11, 5'h0F);
    cyc();
    bus.if_req_i     = 1'b0;
    bus.ls_req_i     = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h66;
    expect_ev(K_LR, 32'h66, 32'd0, 5'd0);
    cyc();
    clear_in();

    // LSU partial write.
    bus.ls_req_i   = 1'b1;
    bus.ls_we_i    = 1'b1;
    bus.ls_be_i    = 4'b0011;
    bus.ls_addr_i  = 32'h8000;
    bus.ls_wdata_i = 32'hDEAD;
    bus.mem_gnt_i  = 1'b1;
    expect_ev(K_LG, 32'h8000, 32'hDEAD, 5'b1_0011);
    cyc();
    bus.ls_req_i     = 1'b0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h0;
    expect_ev(K_LR, 32'h0, 32'd0, 5'd0);
    cyc();
    clear_in();

    // Grant withheld for 5 cycles: request and address stay put.
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h600;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_req_held", 64'(bus.mem_req_o), 64'd1);
      chk("stall_addr_held", 64'(bus.mem_addr_o), 64'h600);
      cyc();
    end
    bus.mem_gnt_i = 1'b1;
    expect_ev(K_IG, 32'h600, 32'd0, 5'h0F);
    cyc();
    bus.if_req_i     = 1'b0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h600D;
    expect_ev(K_IR, 32'h600D, 32'd0, 5'd0);
    cyc();
    clear_in();

    // Reset while waiting on an LSU response; the stale response is ignored.
    bus.ls_req_i  = 1'b1;
    bus.ls_be_i   = 4'hF;
    bus.ls_addr_i = 32'h700;
    bus.mem_gnt_i = 1'b1;
    expect_ev(K_LG, 32'h700, 32'd0, 5'h0F);
    cyc();
    reset = 1'b0;
    #1;
    chk("reset_wait_ls_outputs_zero", 64'(any_out()), 64'd0);
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'h123;
    #1;
    chk("reset_rvalid_outputs_zero", 64'(any_out()), 64'd0);
    cyc();
    reset         = 1'b1;
    bus.ls_req_i  = 1'b0;
    bus.mem_gnt_i = 1'b0;
    #1;
    chk("stale_rvalid_ignored", 64'(bus.ls_rvalid_o), 64'd0);
    cyc();
    clear_in();
    cyc();
    fetch_txn(32'h800, 1, 32'h88);

    cyc();
    cyc();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
